// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 3-digit common-anode 7-segment scan driver fed by the Timer.
// Scans tens/ones/xiaoshu in fixed slots. Each slot opens with a short
// all-off gap to suppress ghosting. Inputs are latched once per frame so a
// digit update never tears across a frame. A steady blink is driven by the
// Timer led flag.
module seg_scan_driver #(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYC    = 4,
  parameter int unsigned BLINK_FRAMES = 167,
  parameter bit          LZ_BLANK     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic [3:0] xiaoshu,
  input  logic       point,
  input  logic       blink,
  output logic [2:0] dig_sel,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int unsigned DivW   = $clog2(CLK_DIV);
  localparam int unsigned BlinkW = $clog2(BLINK_FRAMES + 1);

  localparam logic [DivW-1:0]   DivMax   = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0]   BlankCyc = DivW'(BLANK_CYC);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_FRAMES - 1);

  // Slot index encoding
  localparam logic [1:0] SlotTens = 2'd0;
  localparam logic [1:0] SlotOnes = 2'd1;
  localparam logic [1:0] SlotXs   = 2'd2;

  localparam logic [6:0] SegOff = 7'h7F;

  logic [DivW-1:0]   div_cnt_q, div_cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        sh_tens_q, sh_tens_d;
  logic [3:0]        sh_ones_q, sh_ones_d;
  logic [3:0]        sh_xs_q, sh_xs_d;
  logic              sh_point_q, sh_point_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic [2:0]        dig_sel_d;
  logic [6:0]        seg_d;
  logic              dp_d;

  logic slot_end, frame_end, frame_start;

  assign slot_end    = (div_cnt_q == DivMax);
  assign frame_end   = slot_end && (idx_q == SlotXs);
  assign frame_start = (div_cnt_q == '0) && (idx_q == SlotTens);

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // Prescaler, slot sequencing, per-frame input latch and blink timing.
  always_comb begin
    div_cnt_d     = slot_end ? '0 : div_cnt_q + DivW'(1);
    idx_d         = idx_q;
    sh_tens_d     = sh_tens_q;
    sh_ones_d     = sh_ones_q;
    sh_xs_d       = sh_xs_q;
    sh_point_d    = sh_point_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;

    if (slot_end) begin
      idx_d = (idx_q == SlotXs) ? SlotTens : idx_q + 2'd1;
    end

    if (frame_start) begin
      sh_tens_d  = tens;
      sh_ones_d  = ones;
      sh_xs_d    = xiaoshu;
      sh_point_d = point;
    end

    // Dropping blink always wins, even over a phase toggle on the same edge.
    if (!blink) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (frame_end) begin
      if (blink_cnt_q == BlinkMax) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BlinkW'(1);
      end
    end
  end

  // Display outputs for the current cycle; registered below, one clock behind.
  always_comb begin
    dig_sel_d = 3'b111;
    seg_d     = SegOff;
    dp_d      = 1'b1;
    if (!(div_cnt_q < BlankCyc) && !(blink && blink_phase_q)) begin
      unique case (idx_q)
        SlotTens: begin
          dig_sel_d = 3'b011;
          // Leading zero keeps the digit enabled but lights no segments.
          if (!(LZ_BLANK && (sh_tens_q == 4'd0))) seg_d = seg_decode(sh_tens_q);
        end
        SlotOnes: begin
          dig_sel_d = 3'b101;
          seg_d     = seg_decode(sh_ones_q);
          dp_d      = ~sh_point_q;
        end
        SlotXs: begin
          dig_sel_d = 3'b110;
          seg_d     = seg_decode(sh_xs_q);
        end
        default: begin
          dig_sel_d = 3'b111;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q     <= '0;
      idx_q         <= SlotTens;
      sh_tens_q     <= '0;
      sh_ones_q     <= '0;
      sh_xs_q       <= '0;
      sh_point_q    <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      dig_sel       <= 3'b111;
      seg           <= SegOff;
      dp            <= 1'b1;
      frame_done    <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      idx_q         <= idx_d;
      sh_tens_q     <= sh_tens_d;
      sh_ones_q     <= sh_ones_d;
      sh_xs_q       <= sh_xs_d;
      sh_point_q    <= sh_point_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      dig_sel       <= dig_sel_d;
      seg           <= seg_d;
      dp            <= dp_d;
      frame_done    <= frame_end;
    end
  end

endmodule
